// File: rtl/comm_frame_sequencer_if.sv
// Bus bundle between the host byte stream / frame consumer and comm_frame_sequencer.
// master: host side (drives bytes and ack), slave: the sequencer.
interface comm_frame_sequencer_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              wen;
   logic              dataReady;
   logic [7:0]        inByte;
   logic              frame_ack;
   logic              ready;
   logic              buf_we;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_wdata;
   logic              frame_done;
   logic [15:0]       frame_len;
   logic              frame_err;
   logic [1:0]        err_code;

   modport master (
      output wen, dataReady, inByte, frame_ack,
      input  ready, buf_we, buf_addr, buf_wdata, frame_done, frame_len, frame_err, err_code
   );

   modport slave (
      input  wen, dataReady, inByte, frame_ack,
      output ready, buf_we, buf_addr, buf_wdata, frame_done, frame_len, frame_err, err_code
   );
endinterface

// File: rtl/comm_frame_sequencer.sv
// Receive-side frame parser for the comm byte buffer.
// Frame: SYNC, LEN_HI, LEN_LO, payload[LEN], optional XOR checksum byte.
// Define CHECKSUM_EN to require the trailing checksum byte.
// All outputs are registered; payload writes appear one clock after acceptance.
module comm_frame_sequencer #(
   parameter int unsigned ADDR_W      = 8,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input logic                   clk,
   input logic                   reset,
   comm_frame_sequencer_if.slave bus
);
   localparam int unsigned Depth  = 2 ** ADDR_W;
   localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      StIdle,
      StLenHi,
      StLenLo,
      StPayload,
`ifdef CHECKSUM_EN
      StCsum,
`endif
      StDone
   } state_e;

   state_e              stateQ, stateD;
   logic [15:0]         lenQ, lenD;
   logic [ADDR_W-1:0]   offsetQ, offsetD;
   logic [TimerW-1:0]   timerQ, timerD;
`ifdef CHECKSUM_EN
   logic [7:0]          csumQ, csumD;
`endif
   logic                readyQ, readyD;
   logic                bufWeQ, bufWeD;
   logic [ADDR_W-1:0]   bufAddrQ, bufAddrD;
   logic [7:0]          bufWdataQ, bufWdataD;
   logic                frameDoneQ, frameDoneD;
   logic [15:0]         frameLenQ, frameLenD;
   logic                frameErrQ, frameErrD;
   logic [1:0]          errCodeQ, errCodeD;

   logic                accept;
   logic                inFrame;
   logic                lastByte;
   logic [15:0]         lenNew;

   // Next-state and registered-output decode
   always_comb begin
      stateD    = stateQ;
      lenD      = lenQ;
      offsetD   = offsetQ;
      timerD    = timerQ;
`ifdef CHECKSUM_EN
      csumD     = csumQ;
`endif
      errCodeD  = errCodeQ;
      frameErrD = 1'b0;
      bufWeD    = 1'b0;
      bufAddrD  = bufAddrQ;
      bufWdataD = bufWdataQ;

      accept   = bus.dataReady & bus.wen & readyQ;
      inFrame  = (stateQ != StIdle) && (stateQ != StDone);
      lenNew   = {lenQ[15:8], bus.inByte};
      lastByte = (32'(offsetQ) + 32'd1) == 32'(lenQ);

      // Inter-byte idle counter, only meaningful inside a frame
      if (inFrame) begin
         timerD = accept ? '0 : timerQ + 1'b1;
      end

      unique case (stateQ)
         StIdle: begin
            if (accept && bus.inByte == SYNC_BYTE) begin
               stateD   = StLenHi;
               errCodeD = 2'd0;
               timerD   = '0;
            end
         end
         StLenHi: begin
            if (accept) begin
               lenD[15:8] = bus.inByte;
               stateD     = StLenLo;
            end
         end
         StLenLo: begin
            if (accept) begin
               lenD = lenNew;
               if (lenNew == 16'd0 || 32'(lenNew) > Depth) begin
                  frameErrD = 1'b1;
                  errCodeD  = 2'd1;
                  stateD    = StIdle;
               end else begin
                  offsetD = '0;
`ifdef CHECKSUM_EN
                  csumD   = 8'd0;
`endif
                  stateD  = StPayload;
               end
            end
         end
         StPayload: begin
            if (accept) begin
               bufWeD    = 1'b1;
               bufAddrD  = offsetQ;
               bufWdataD = bus.inByte;
`ifdef CHECKSUM_EN
               csumD     = csumQ ^ bus.inByte;
`endif
               if (lastByte) begin
`ifdef CHECKSUM_EN
                  stateD = StCsum;
`else
                  stateD = StDone;
`endif
               end else begin
                  // Held on the last byte so a full-depth frame never wraps
                  offsetD = offsetQ + 1'b1;
               end
            end
         end
`ifdef CHECKSUM_EN
         StCsum: begin
            if (accept) begin
               if (bus.inByte == csumQ) begin
                  stateD = StDone;
               end else begin
                  frameErrD = 1'b1;
                  errCodeD  = 2'd2;
                  stateD    = StIdle;
               end
            end
         end
`endif
         StDone: begin
            if (bus.frame_ack) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase

      // Stalled frame abort; accept is 0 here so no other transition competes
      if (inFrame && !accept && timerQ == TimerW'(TIMEOUT_CYC - 1)) begin
         frameErrD = 1'b1;
         errCodeD  = 2'd3;
         stateD    = StIdle;
         timerD    = '0;
      end

      readyD     = (stateD != StDone);
      frameDoneD = (stateD == StDone);
      frameLenD  = (stateD == StDone) ? lenQ : 16'd0;
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ     <= StIdle;
         lenQ       <= 16'd0;
         offsetQ    <= '0;
         timerQ     <= '0;
`ifdef CHECKSUM_EN
         csumQ      <= 8'd0;
`endif
         readyQ     <= 1'b1;
         bufWeQ     <= 1'b0;
         bufAddrQ   <= '0;
         bufWdataQ  <= 8'd0;
         frameDoneQ <= 1'b0;
         frameLenQ  <= 16'd0;
         frameErrQ  <= 1'b0;
         errCodeQ   <= 2'd0;
      end else begin
         stateQ     <= stateD;
         lenQ       <= lenD;
         offsetQ    <= offsetD;
         timerQ     <= timerD;
`ifdef CHECKSUM_EN
         csumQ      <= csumD;
`endif
         readyQ     <= readyD;
         bufWeQ     <= bufWeD;
         bufAddrQ   <= bufAddrD;
         bufWdataQ  <= bufWdataD;
         frameDoneQ <= frameDoneD;
         frameLenQ  <= frameLenD;
         frameErrQ  <= frameErrD;
         errCodeQ   <= errCodeD;
      end
   end

   assign bus.ready      = readyQ;
   assign bus.buf_we     = bufWeQ;
   assign bus.buf_addr   = bufAddrQ;
   assign bus.buf_wdata  = bufWdataQ;
   assign bus.frame_done = frameDoneQ;
   assign bus.frame_len  = frameLenQ;
   assign bus.frame_err  = frameErrQ;
   assign bus.err_code   = errCodeQ;
endmodule

// File: tb/tb_comm_frame_sequencer.sv
// Directed bench for comm_frame_sequencer: per-cycle vector table plus
// hand-written sequences for full-depth frame, timeout and async reset.
module tb_comm_frame_sequencer;
   localparam int unsigned ADDR_W = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   comm_frame_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   comm_frame_sequencer #(
      .ADDR_W(ADDR_W),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT_CYC(1000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic        w;
      logic        dr;
      logic [7:0]  b;
      logic        ack;
      logic        eRdy;
      logic        eWe;
      logic [7:0]  eAddr;
      logic [7:0]  eData;
      logic        eDone;
      logic [15:0] eLen;
      logic        eErr;
      logic [1:0]  eCode;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic addV(input logic w, input logic dr, input logic [7:0] b, input logic ack,
                       input logic eRdy, input logic eWe, input logic [7:0] eAddr,
                       input logic [7:0] eData, input logic eDone, input logic [15:0] eLen,
                       input logic eErr, input logic [1:0] eCode);
      vec_t v;
      v.w = w; v.dr = dr; v.b = b; v.ack = ack;
      v.eRdy = eRdy; v.eWe = eWe; v.eAddr = eAddr; v.eData = eData;
      v.eDone = eDone; v.eLen = eLen; v.eErr = eErr; v.eCode = eCode;
      vecs.push_back(v);
   endtask

   // Accepted-looking byte with no write, not done, no error
   task automatic nb(input logic [7:0] b, input logic [1:0] code);
      addV(1, 1, b, 0, 1, 0, 0, 0, 0, 0, 0, code);
   endtask

   task automatic sendB(input logic [7:0] b);
      bus.wen       = 1'b1;
      bus.dataReady = 1'b1;
      bus.inByte    = b;
      @(negedge clk);
      bus.dataReady = 1'b0;
   endtask

   task automatic sendAck();
      bus.frame_ack = 1'b1;
      @(negedge clk);
      bus.frame_ack = 1'b0;
   endtask

   task automatic waitTimeout(input int id);
      int early = 0;
      repeat (999) begin
         @(negedge clk);
         if (bus.frame_err) early++;
      end
      chk("to_early_err", id, early, 0);
      @(negedge clk);
      chk("to_err", id, bus.frame_err, 1);
      chk("to_code", id, bus.err_code, 3);
      chk("to_ready", id, bus.ready, 1);
      @(negedge clk);
      chk("to_err_pulse", id, bus.frame_err, 0);
      chk("to_code_hold", id, bus.err_code, 3);
   endtask

   task automatic shortFrame(input int id);
      sendB(8'hA5); sendB(8'h00); sendB(8'h01); sendB(8'h7E);
      chk("sf_we", id, bus.buf_we, 1);
      chk("sf_addr", id, bus.buf_addr, 0);
      chk("sf_data", id, bus.buf_wdata, 8'h7E);
`ifdef CHECKSUM_EN
      sendB(8'h7E);
`endif
      chk("sf_done", id, bus.frame_done, 1);
      chk("sf_len", id, bus.frame_len, 1);
      sendAck();
      chk("sf_ready", id, bus.ready, 1);
   endtask

   initial begin
      int badAddr;
      reset         = 1'b1;
      bus.wen       = 1'b0;
      bus.dataReady = 1'b0;
      bus.inByte    = 8'h00;
      bus.frame_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 0, bus.ready, 1);
      chk("rst_we", 0, bus.buf_we, 0);
      chk("rst_done", 0, bus.frame_done, 0);
      chk("rst_err", 0, bus.frame_err, 0);
      chk("rst_code", 0, bus.err_code, 0);
      chk("rst_len", 0, bus.frame_len, 0);
      reset = 1'b0;
      @(negedge clk);

      // Basic frame: A5 00 03 11 22 33 [00]
      nb(8'hA5, 0); nb(8'h00, 0); nb(8'h03, 0);
      addV(1, 1, 8'h11, 0, 1, 1, 8'h00, 8'h11, 0, 0, 0, 0);
      addV(1, 1, 8'h22, 0, 1, 1, 8'h01, 8'h22, 0, 0, 0, 0);
`ifdef CHECKSUM_EN
      addV(1, 1, 8'h33, 0, 1, 1, 8'h02, 8'h33, 0, 0, 0, 0);
      addV(1, 1, 8'h00, 0, 0, 0, 0, 0, 1, 3, 0, 0);
`else
      addV(1, 1, 8'h33, 0, 0, 1, 8'h02, 8'h33, 1, 3, 0, 0);
`endif
      addV(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 3, 0, 0);
      addV(1, 1, 8'h77, 0, 0, 0, 0, 0, 1, 3, 0, 0);
      addV(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      addV(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      // Leading junk discarded, one-byte frame
      nb(8'h55, 0); nb(8'hA5, 0); nb(8'h00, 0); nb(8'h01, 0);
`ifdef CHECKSUM_EN
      addV(1, 1, 8'h7E, 0, 1, 1, 8'h00, 8'h7E, 0, 0, 0, 0);
      addV(1, 1, 8'h7E, 0, 0, 0, 0, 0, 1, 1, 0, 0);
`else
      addV(1, 1, 8'h7E, 0, 0, 1, 8'h00, 8'h7E, 1, 1, 0, 0);
`endif
      addV(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      // Length errors: zero and DEPTH+1
      nb(8'hA5, 0); nb(8'h00, 0);
      addV(1, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1, 1);
      addV(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      addV(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      nb(8'hA5, 0); nb(8'h01, 0);
      addV(1, 1, 8'h01, 0, 1, 0, 0, 0, 0, 0, 1, 1);
      addV(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      // Byte with wen low is dropped: length becomes 00 01
      nb(8'hA5, 0); nb(8'h00, 0);
      addV(0, 1, 8'h02, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      nb(8'h01, 0);
`ifdef CHECKSUM_EN
      addV(1, 1, 8'h7E, 0, 1, 1, 8'h00, 8'h7E, 0, 0, 0, 0);
      addV(1, 1, 8'h7E, 0, 0, 0, 0, 0, 1, 1, 0, 0);
`else
      addV(1, 1, 8'h7E, 0, 0, 1, 8'h00, 8'h7E, 1, 1, 0, 0);
`endif
      addV(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      // SYNC value inside payload is data
      nb(8'hA5, 0); nb(8'h00, 0); nb(8'h02, 0);
      addV(1, 1, 8'hA5, 0, 1, 1, 8'h00, 8'hA5, 0, 0, 0, 0);
`ifdef CHECKSUM_EN
      addV(1, 1, 8'h3C, 0, 1, 1, 8'h01, 8'h3C, 0, 0, 0, 0);
      addV(1, 1, 8'h99, 0, 0, 0, 0, 0, 1, 2, 0, 0);
`else
      addV(1, 1, 8'h3C, 0, 0, 1, 8'h01, 8'h3C, 1, 2, 0, 0);
`endif
      addV(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef CHECKSUM_EN
      // Bad checksum then good checksum
      nb(8'hA5, 0); nb(8'h00, 0); nb(8'h02, 0);
      addV(1, 1, 8'h0F, 0, 1, 1, 8'h00, 8'h0F, 0, 0, 0, 0);
      addV(1, 1, 8'hF0, 0, 1, 1, 8'h01, 8'hF0, 0, 0, 0, 0);
      addV(1, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1, 2);
      addV(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 2);
      nb(8'hA5, 0); nb(8'h00, 0); nb(8'h02, 0);
      addV(1, 1, 8'h0F, 0, 1, 1, 8'h00, 8'h0F, 0, 0, 0, 0);
      addV(1, 1, 8'hF0, 0, 1, 1, 8'h01, 8'hF0, 0, 0, 0, 0);
      addV(1, 1, 8'hFF, 0, 0, 0, 0, 0, 1, 2, 0, 0);
      addV(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0);
`endif

      foreach (vecs[i]) begin
         bus.wen       = vecs[i].w;
         bus.dataReady = vecs[i].dr;
         bus.inByte    = vecs[i].b;
         bus.frame_ack = vecs[i].ack;
         @(negedge clk);
         chk("ready", i, bus.ready, vecs[i].eRdy);
         chk("buf_we", i, bus.buf_we, vecs[i].eWe);
         if (vecs[i].eWe) begin
            chk("buf_addr", i, bus.buf_addr, vecs[i].eAddr);
            chk("buf_wdata", i, bus.buf_wdata, vecs[i].eData);
         end
         chk("frame_done", i, bus.frame_done, vecs[i].eDone);
         chk("frame_len", i, bus.frame_len, vecs[i].eLen);
         chk("frame_err", i, bus.frame_err, vecs[i].eErr);
         chk("err_code", i, bus.err_code, vecs[i].eCode);
      end
      bus.wen       = 1'b1;
      bus.dataReady = 1'b0;
      bus.frame_ack = 1'b0;
      @(negedge clk);

      // Full-depth frame: 256 bytes, addresses 0..255, no wrap
      sendB(8'hA5); sendB(8'h01); sendB(8'h00);
      chk("full_no_err", 0, bus.frame_err, 0);
      badAddr = 0;
      for (int i = 0; i < 256; i++) begin
         sendB(8'(i));
         if (bus.buf_we !== 1'b1 || bus.buf_addr !== 8'(i) || bus.buf_wdata !== 8'(i))
            badAddr++;
      end
      chk("full_writes", 0, badAddr, 0);
`ifdef CHECKSUM_EN
      sendB(8'h00);
`endif
      chk("full_done", 0, bus.frame_done, 1);
      chk("full_len", 0, bus.frame_len, 256);
      sendAck();

      // Timeout with no further bytes
      sendB(8'hA5); sendB(8'h00); sendB(8'h04);
      waitTimeout(0);
      shortFrame(0);

      // Accepted byte restarts the count; blocked bytes (wen=0) do not
      sendB(8'hA5); sendB(8'h00); sendB(8'h04);
      repeat (500) @(negedge clk);
      sendB(8'h11);
      chk("to2_we", 0, bus.buf_we, 1);
      bus.wen       = 1'b0;
      bus.dataReady = 1'b1;
      waitTimeout(1);
      bus.dataReady = 1'b0;
      bus.wen       = 1'b1;
      shortFrame(1);

      // Asynchronous reset mid-payload
      sendB(8'hA5); sendB(8'h00); sendB(8'h05); sendB(8'h11); sendB(8'h22);
      #2 reset = 1'b1;
      #1;
      chk("arst_ready", 0, bus.ready, 1);
      chk("arst_we", 0, bus.buf_we, 0);
      chk("arst_addr", 0, bus.buf_addr, 0);
      chk("arst_wdata", 0, bus.buf_wdata, 0);
      chk("arst_done", 0, bus.frame_done, 0);
      chk("arst_err", 0, bus.frame_err, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("arst_no_err", 0, bus.frame_err, 0);
      shortFrame(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
